// File: rtl/mem1_pkg.sv
// Shared widths and FSM state encoding for the mem1 memory-access stage.
// Imported by mem1 and its alignment helper.
package mem1_pkg;

  localparam int REG_SIZE  = 32;
  localparam int ADDR_SIZE = 32;
  localparam int REG_ADDR  = 5;
  localparam int MEM_BE_W  = 4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } memState_e;

endpackage

// File: rtl/mem1_align.sv
// Combinational lane logic for mem1: byte enables, lane-replicated store data
// and sign-extended load data, all little-endian.
module mem_align
  import mem1_pkg::*;
(
  input  logic [1:0]          addrLsb_i,
  input  logic                byteOp_i,
  input  logic [REG_SIZE-1:0] storeData_i,
  input  logic [REG_SIZE-1:0] readData_i,
  output logic [MEM_BE_W-1:0] byteEn_o,
  output logic [REG_SIZE-1:0] storeData_o,
  output logic [REG_SIZE-1:0] loadData_o
);

  logic [7:0] laneByte;

  always_comb begin
    laneByte = readData_i[7:0];
    case (addrLsb_i)
      2'd1:    laneByte = readData_i[15:8];
      2'd2:    laneByte = readData_i[23:16];
      2'd3:    laneByte = readData_i[31:24];
      default: laneByte = readData_i[7:0];
    endcase
  end

  always_comb begin
    byteEn_o    = '1;
    storeData_o = storeData_i;
    loadData_o  = readData_i;
    if (byteOp_i) begin
      byteEn_o    = MEM_BE_W'(1) << addrLsb_i;
      storeData_o = {4{storeData_i[7:0]}};
      loadData_o  = {{24{laneByte[7]}}, laneByte};
    end
  end

endmodule

// File: rtl/mem1.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack data-memory
// port, stalls upstream while an access is in flight, and registers writeback.
module mem1
  import mem1_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regwrite_in,
  input  logic                 memread,
  input  logic                 memwrite,
  input  logic                 byte_op,
  input  logic [REG_SIZE-1:0]  alu_result,
  input  logic [REG_SIZE-1:0]  data_store,
  input  logic [REG_ADDR-1:0]  wreg_in,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_SIZE-1:0] dmem_addr,
  output logic [REG_SIZE-1:0]  dmem_wdata,
  output logic [MEM_BE_W-1:0]  dmem_be,
  input  logic                 dmem_ack,
  input  logic [REG_SIZE-1:0]  dmem_rdata,
  output logic                 stall,
  output logic                 regwrite_out,
  output logic [REG_SIZE-1:0]  wb_data,
  output logic [REG_ADDR-1:0]  dst_reg,
  output logic                 mem_fault
);

  memState_e state_q, state_d;

  logic                 dmemReq_q, dmemWe_q;
  logic [ADDR_SIZE-1:0] dmemAddr_q;
  logic [REG_SIZE-1:0]  dmemWdata_q;
  logic [MEM_BE_W-1:0]  dmemBe_q;
  logic [REG_SIZE-1:0]  loadData_q;
  logic                 regwrite_q, fault_q;
  logic [REG_SIZE-1:0]  wbData_q;
  logic [REG_ADDR-1:0]  dstReg_q;

  logic faultC, access, issue, capture, stallC;
  logic [MEM_BE_W-1:0] alignBe;
  logic [REG_SIZE-1:0] alignStore, alignLoad;

  // Double-op and misaligned word accesses fault instead of touching memory.
  assign faultC = (memread & memwrite) |
                  (~byte_op & (memread | memwrite) & (alu_result[1:0] != 2'b00));
  assign access = (memread | memwrite) & ~faultC;

  mem_align u_align (
    .addrLsb_i   (alu_result[1:0]),
    .byteOp_i    (byte_op),
    .storeData_i (data_store),
    .readData_i  (loadData_q),
    .byteEn_o    (alignBe),
    .storeData_o (alignStore),
    .loadData_o  (alignLoad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MEM_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (access)   state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ack) state_d = MEM_DONE;
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    issue   = (state_q == MEM_IDLE) & access;
    capture = (state_q == MEM_WAIT) & dmem_ack;
    stallC  = issue | (state_q == MEM_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmemReq_q   <= 1'b0;
      dmemWe_q    <= 1'b0;
      dmemAddr_q  <= '0;
      dmemWdata_q <= '0;
      dmemBe_q    <= '0;
      loadData_q  <= '0;
    end else begin
      if (issue) begin
        dmemReq_q   <= 1'b1;
        dmemWe_q    <= memwrite;
        dmemAddr_q  <= {alu_result[ADDR_SIZE-1:2], 2'b00};
        dmemWdata_q <= alignStore;
        dmemBe_q    <= alignBe;
      end else if (capture) begin
        dmemReq_q <= 1'b0;
      end
      if (capture && memread) loadData_q <= dmem_rdata;
    end
  end

  // A stalled edge emits a bubble; DONE releases the stall so the load lands here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      fault_q    <= 1'b0;
      wbData_q   <= '0;
      dstReg_q   <= '0;
    end else if (stallC) begin
      regwrite_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      regwrite_q <= regwrite_in & ~faultC;
      fault_q    <= faultC;
      wbData_q   <= memread ? alignLoad : alu_result;
      dstReg_q   <= wreg_in;
    end
  end

  assign dmem_req     = dmemReq_q;
  assign dmem_we      = dmemWe_q;
  assign dmem_addr    = dmemAddr_q;
  assign dmem_wdata   = dmemWdata_q;
  assign dmem_be      = dmemBe_q;
  assign stall        = stallC;
  assign regwrite_out = regwrite_q;
  assign wb_data      = wbData_q;
  assign dst_reg      = dstReg_q;
  assign mem_fault    = fault_q;

endmodule

// File: tb/tb_mem1.sv
// Self-checking bench for mem1: vector table for single-cycle ops, directed
// multi-cycle sequences, and random ops against a byte-level memory model.
module tb_mem1;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_in, memread, memwrite, byte_op;
  logic [31:0] alu_result, data_store;
  logic [4:0]  wreg_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, regwrite_out;
  logic [31:0] wb_data;
  logic [4:0]  dst_reg;
  logic        mem_fault;

  int checks = 0;
  int errors = 0;

  logic [7:0]  refBytes [64];
  logic [31:0] wordMem  [16];

  always #5 clk = ~clk;

  mem1 dut (
    .clk(clk), .reset(reset), .regwrite_in(regwrite_in), .memread(memread),
    .memwrite(memwrite), .byte_op(byte_op), .alu_result(alu_result),
    .data_store(data_store), .wreg_in(wreg_in), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .regwrite_out(regwrite_out), .wb_data(wb_data),
    .dst_reg(dst_reg), .mem_fault(mem_fault)
  );

  typedef struct {
    logic        rw, rd, wr, bo;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        expRw, expFault, chkWb;
    logic [31:0] expWb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic rd, input logic wr, input logic bo,
                               input logic [31:0] alu, input logic [31:0] ds, input logic [4:0] wreg);
    regwrite_in = rw; memread = rd; memwrite = wr; byte_op = bo;
    alu_result = alu; data_store = ds; wreg_in = wreg;
  endtask

  // Op that never touches memory (non-memory op or faulting access).
  task automatic singleCycleOp(input vec_t v);
    applyStimulus(v.rw, v.rd, v.wr, v.bo, v.alu, $urandom, v.wreg);
    #1;
    checkOutput("no stall", stall, 1'b0);
    @(posedge clk); #1;
    checkOutput("regwrite_out", regwrite_out, v.expRw);
    checkOutput("mem_fault", mem_fault, v.expFault);
    checkOutput("dst_reg", dst_reg, v.wreg);
    checkOutput("no request", dmem_req, 1'b0);
    if (v.chkWb) checkOutput("wb_data", wb_data, v.expWb);
  endtask

  task automatic memOp(input logic rw, input logic rd, input logic wr, input logic bo,
                       input logic [31:0] addr, input logic [31:0] ds, input logic [4:0] wreg,
                       input int k, input logic [31:0] rdata, input logic [31:0] expWb,
                       input logic [3:0] expBe, input logic [31:0] expWdata);
    applyStimulus(rw, rd, wr, bo, addr, ds, wreg);
    #1;
    checkOutput("stall at issue", stall, 1'b1);
    @(posedge clk); #1;
    checkOutput("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
    checkOutput("dmem_we", dmem_we, wr);
    if (wr) begin
      checkOutput("dmem_be", dmem_be, expBe);
      checkOutput("dmem_wdata", dmem_wdata, expWdata);
    end
    for (int i = 1; i <= k; i++) begin
      checkOutput("stall in wait", stall, 1'b1);
      checkOutput("dmem_req in wait", dmem_req, 1'b1);
      checkOutput("bubble regwrite", regwrite_out, 1'b0);
      if (i == k) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
    end
    checkOutput("stall in done", stall, 1'b0);
    checkOutput("dmem_req in done", dmem_req, 1'b0);
    checkOutput("bubble regwrite done", regwrite_out, 1'b0);
    @(posedge clk); #1;
    checkOutput("mem regwrite_out", regwrite_out, rw);
    checkOutput("mem wb_data", wb_data, expWb);
    checkOutput("mem dst_reg", dst_reg, wreg);
    checkOutput("mem mem_fault", mem_fault, 1'b0);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] a, d, rdata, expWb, expWd, w;
    logic [3:0]  expBe;
    logic        bo, rd, wr, rw, fault;
    logic [4:0]  wr5;
    logic [5:0]  b;
    int          kind;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678, 5'd3,  1'b1, 1'b0, 1'b1, 32'h12345678};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 5'd31, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00000102, 5'd7,  1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00000040, 5'd8,  1'b0, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00000101, 5'd9,  1'b0, 1'b1, 1'b1, 32'h00000101};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 5'd1,  1'b1, 1'b0, 1'b1, 32'hCAFEF00D};

    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      wordMem[i] = w;
      for (int j = 0; j < 4; j++) refBytes[4*i+j] = w[8*j +: 8];
    end

    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    checkOutput("reset dmem_req", dmem_req, 1'b0);
    checkOutput("reset dmem_we", dmem_we, 1'b0);
    checkOutput("reset dmem_addr", dmem_addr, 32'h0);
    checkOutput("reset dmem_be", dmem_be, 4'h0);
    checkOutput("reset regwrite_out", regwrite_out, 1'b0);
    checkOutput("reset wb_data", wb_data, 32'h0);
    checkOutput("reset mem_fault", mem_fault, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) singleCycleOp(vecs[i]);

    // Word load, ack in the second WAIT cycle.
    memOp(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd4, 2, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 32'h0);
    // Byte store to the top lane.
    memOp(1'b0, 1'b0, 1'b1, 1'b1, 32'h203, 32'h000000A5, 5'd5, 1, 32'h0, 32'h203, 4'b1000, 32'hA5A5A5A5);
    // Byte load of a negative byte in lane 1.
    memOp(1'b1, 1'b1, 1'b0, 1'b1, 32'h201, 32'h0, 5'd6, 1, 32'h00008000, 32'hFFFFFF80, 4'h0, 32'h0);

    // Reset in the middle of an access, then a stray ack.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd2);
    @(posedge clk); #1;
    checkOutput("req before reset", dmem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("reset mid dmem_req", dmem_req, 1'b0);
    checkOutput("reset mid wb_data", wb_data, 32'h0);
    checkOutput("reset mid dst_reg", dst_reg, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    checkOutput("stray ack stall", stall, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checkOutput("stray ack dmem_req", dmem_req, 1'b0);
    checkOutput("stray ack wb_data", wb_data, 32'h0);
    checkOutput("stray ack stall idle", stall, 1'b0);
    checkOutput("stray ack regwrite", regwrite_out, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      rw   = 1'($urandom);
      wr5  = 5'($urandom);
      d    = $urandom;
      bo   = 1'($urandom);
      a    = $urandom;
      if (!bo && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
      rd = (kind >= 3 && kind <= 5) || kind == 9;
      wr = (kind >= 6);
      fault = (rd & wr) | (~bo & (rd | wr) & (a[1:0] != 2'b00));
      b = a[5:0];
      if (!(rd || wr) || fault) begin
        v = '{rw, rd, wr, bo, a, wr5, rw & ~fault, fault, ~rd, a};
        singleCycleOp(v);
      end else begin
        expBe = bo ? (4'b0001 << a[1:0]) : 4'hF;
        expWd = bo ? {4{d[7:0]}} : d;
        rdata = wordMem[a[5:2]];
        if (rd) begin
          if (bo) expWb = {{24{refBytes[b][7]}}, refBytes[b]};
          else    expWb = {refBytes[b+3], refBytes[b+2], refBytes[b+1], refBytes[b]};
        end else begin
          expWb = a;
        end
        memOp(rw, rd, wr, bo, a, d, wr5, $urandom_range(1, 3), rdata, expWb, expBe, expWd);
        if (wr) begin
          for (int j = 0; j < 4; j++)
            if (expBe[j]) wordMem[a[5:2]][8*j +: 8] = expWd[8*j +: 8];
          if (bo) refBytes[b] = d[7:0];
          else for (int j = 0; j < 4; j++) refBytes[b+j] = d[8*j +: 8];
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem1.md
# mem1

Memory-access pipeline stage fed directly by the registered outputs of the execute stage. Uses the execute result as a data-memory address, runs loads and stores over a req/ack data-memory interface, and stalls upstream stages while an access is in flight. Registers the writeback value, destination register and write permission for the writeback stage.

## Interface
Parameters (all widths come from `define.v`):
- `REG_SIZE`, 32: data and register width.
- `ADDR_SIZE`, 32: address width.
- `REG_ADDR`, 5: register-index width.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `regwrite_in`  in  1  write permission from execute.
- `memread`  in  1  load instruction.
- `memwrite`  in  1  store instruction.
- `byte_op`  in  1  1 = byte access, 0 = word access.
- `alu_result`  in  REG_SIZE  effective address, or the result for non-memory ops.
- `data_store`  in  REG_SIZE  store data.
- `wreg_in`  in  REG_ADDR  destination register.
- `dmem_req`  out  1  registered access request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_SIZE  word-aligned address: `{alu_result[31:2], 2'b00}`.
- `dmem_wdata`  out  REG_SIZE  write data.
- `dmem_be`  out  4  byte enables.
- `dmem_ack`  in  1  one-cycle completion pulse.
- `dmem_rdata`  in  REG_SIZE  read data, valid when `dmem_ack` = 1.
- `stall`  out  1  combinational; upstream holds all inputs while it is 1.
- `regwrite_out`  out  1  registered write permission.
- `wb_data`  out  REG_SIZE  registered writeback value.
- `dst_reg`  out  REG_ADDR  registered destination register.
- `mem_fault`  out  1  registered one-cycle fault pulse.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- `access` = (`memread` | `memwrite`) & !`fault_c`.
- `fault_c` = (`memread` & `memwrite`) | (!`byte_op` & (`memread` | `memwrite`) & `alu_result[1:0]` != 0).
- State transitions:
  - IDLE → WAIT when `access`. The same edge sets `dmem_req` = 1 and registers `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_be`.
  - WAIT → DONE on `dmem_ack`. The same edge clears `dmem_req` and captures `dmem_rdata` into the load register (loads only).
  - DONE → IDLE unconditionally.
- `stall` = (IDLE & `access`) | WAIT. It is 0 in DONE.
- Output register update on every edge:
  - When `stall` = 0: `regwrite_out` <= `regwrite_in` & !`fault_c`; `dst_reg` <= `wreg_in`; `wb_data` <= aligned load data if `memread`, else `alu_result`; `mem_fault` <= `fault_c`.
  - When `stall` = 1: `regwrite_out` <= 0 (bubble) and `mem_fault` <= 0. `wb_data` and `dst_reg` hold.
- Word store: `dmem_wdata` = `data_store`, `dmem_be` = 4'b1111.
- Byte store: `dmem_wdata` = `data_store[7:0]` replicated into all four lanes; `dmem_be` = 1 << `alu_result[1:0]`. Byte order is little-endian.
- Word load: data as read.
- Byte load: lane `alu_result[1:0]` is selected and sign-extended to 32 bits.
- A faulting instruction issues no request, does not stall, and writes no register.
- `dmem_ack` outside WAIT is ignored.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `regwrite_out` and `mem_fault` = 0; `dmem_addr`, `dmem_wdata`, `wb_data` and `dst_reg` = 0; `dmem_be` = 0.
- Non-memory op: latency 1, so outputs are valid on the edge after the input is presented. Throughput is 1 per cycle.
- Memory op presented in cycle 0 with `dmem_ack` arriving in WAIT cycle k (k ≥ 1):
  - `stall` = 1 for cycles 0..k.
  - DONE occupies cycle k+1.
  - Outputs become valid after the edge ending cycle k+1.
  - Minimum latency is 3 edges.
- `dmem_ack` cannot coincide with the edge that raises `dmem_req`, because the request is registered.
- Back-to-back memory ops: the next op is evaluated in the IDLE cycle following DONE. There are no gaps beyond the DONE cycle.
- Reset asserted mid-access: everything returns to reset values immediately. A pending `dmem_ack` after reset is ignored.

## Structure
- Add to `define.v`: `MEM_BE_W` = 4; macros `MEM_IDLE`, `MEM_WAIT`, `MEM_DONE` (2-bit state encoding).
- One natural sub-module: `mem_align`, purely combinational. It takes the address LSBs, `byte_op` and the raw read/store data, and produces the byte enables, the lane-replicated store data and the sign-extended load data. `mem1` owns the FSM and all registers.

## Test plan
- ALU passthrough: `alu_result` = 0x12345678, `wreg_in` = 3, `regwrite_in` = 1, no memory op → next edge: `wb_data` = 0x12345678, `dst_reg` = 3, `regwrite_out` = 1, `stall` never 1.
- Word load at 0x100, `dmem_ack` after 2 WAIT cycles with `dmem_rdata` = 0xDEADBEEF → `dmem_req` high for exactly 2 cycles; `stall` high for 3 cycles; `wb_data` = 0xDEADBEEF after DONE; `regwrite_out` = 0 on every stall edge.
- Byte store at 0x203, `data_store` = 0x000000A5 → `dmem_addr` = 0x200, `dmem_be` = 4'b1000, `dmem_wdata` = 0xA5A5A5A5, `dmem_we` = 1.
- Byte load at 0x201, `dmem_rdata` = 0x00008000 → `wb_data` = 0xFFFFFF80.
- Misaligned word load at 0x102, then `memread` = `memwrite` = 1 → `mem_fault` pulses 1 cycle each; `dmem_req` stays 0; `regwrite_out` = 0; no stall.
- `reset` raised during WAIT, followed by a stray `dmem_ack` → `dmem_req` = 0 immediately; FSM stays IDLE; `wb_data` = 0; the stray ack has no effect.
